// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if -- byte stream in from a PS/2 receiver, decoded key state out.
//   rx_data   : scan-code byte from the receiver
//   rx_valid  : one-cycle strobe qualifying rx_data
//   key       : code of the currently held mapped key, KEY_NONE when none
//   key_valid : one-cycle pulse when key takes a new non-NONE value
//   key_held  : high while key != KEY_NONE
//   err       : one-cycle pulse on prefix timeout or overrun byte
// master = byte source / key consumer, slave = the decoder.
interface ps2_key_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  logic       err;

  modport master (
    output rx_data, rx_valid,
    input  key, key_valid, key_held, err
  );

  modport slave (
    input  rx_data, rx_valid,
    output key, key_valid, key_held, err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder -- turns a PS/2 set-2 scan-code byte stream into a held-key
// level plus a new-key pulse, for a small fixed key set.
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   bus : ps2_key_decoder_if.slave (rx_data/rx_valid in; key, key_valid,
//         key_held, err out -- all outputs registered, 1 cycle after rx_valid)
// Parameter TIMEOUT_CYCLES: max clk cycles allowed between a prefix byte
// (E0/F0) and the byte that completes it.

package my_function;
  localparam logic [3:0] KEY_NONE  = 4'h0;
  localparam logic [3:0] KEY_1     = 4'h1;
  localparam logic [3:0] KEY_2     = 4'h2;
  localparam logic [3:0] KEY_3     = 4'h3;
  localparam logic [3:0] KEY_4     = 4'h4;
  localparam logic [3:0] KEY_UP    = 4'hA;
  localparam logic [3:0] KEY_DOWN  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_ESC   = 4'hF;

  // Plain (unprefixed) make/break code -> key code, KEY_NONE if unmapped.
  function automatic logic [3:0] map_plain(input logic [7:0] code);
    case (code)
      8'h16:   map_plain = KEY_1;
      8'h1E:   map_plain = KEY_2;
      8'h26:   map_plain = KEY_3;
      8'h25:   map_plain = KEY_4;
      8'h5A:   map_plain = KEY_ENTER;
      8'h76:   map_plain = KEY_ESC;
      default: map_plain = KEY_NONE;
    endcase
  endfunction

  // E0-prefixed code -> key code, KEY_NONE if unmapped.
  function automatic logic [3:0] map_ext(input logic [7:0] code);
    case (code)
      8'h75:   map_ext = KEY_UP;
      8'h72:   map_ext = KEY_DOWN;
      default: map_ext = KEY_NONE;
    endcase
  endfunction
endpackage

module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 6_500_000
) (
  input  logic               clk,
  input  logic               rst,
  ps2_key_decoder_if.slave   bus
);
  import my_function::*;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] EXT     = 2'd1;
  localparam logic [1:0] BRK     = 2'd2;
  localparam logic [1:0] EXT_BRK = 2'd3;

  localparam logic [22:0] TIMEOUT_LAST = 23'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_reg, state_next;
  logic [22:0] cnt_reg, cnt_next;
  logic [3:0]  key_reg, key_next;
  logic        key_valid_reg, key_valid_next;
  logic        key_held_reg, key_held_next;
  logic        err_reg, err_next;

  logic [3:0]  plain_code;
  logic [3:0]  ext_code;
  logic [3:0]  make_code;
  logic [3:0]  brk_code;
  logic        do_make;
  logic        do_brk;

  assign plain_code = map_plain(bus.rx_data);
  assign ext_code   = map_ext(bus.rx_data);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    key_next       = key_reg;
    key_valid_next = 1'b0;
    err_next       = 1'b0;
    make_code      = KEY_NONE;
    brk_code       = KEY_NONE;
    do_make        = 1'b0;
    do_brk         = 1'b0;

    if (bus.rx_valid) begin
      cnt_next = '0;
      if (bus.rx_data == 8'h00 || bus.rx_data == 8'hFF) begin
        // Receiver overrun: whatever was in flight is lost, including
        // a possible break, so drop the held key rather than risk a stuck key.
        state_next = IDLE;
        key_next   = KEY_NONE;
        err_next   = 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.rx_data == 8'hE0)      state_next = EXT;
            else if (bus.rx_data == 8'hF0) state_next = BRK;
            else begin
              // BAT (AA) and FC map to KEY_NONE, so they fall out as no-ops.
              do_make   = 1'b1;
              make_code = plain_code;
            end
          end
          EXT: begin
            if (bus.rx_data == 8'hF0) state_next = EXT_BRK;
            else begin
              do_make    = 1'b1;
              make_code  = ext_code;
              state_next = IDLE;
            end
          end
          BRK: begin
            do_brk     = 1'b1;
            brk_code   = plain_code;
            state_next = IDLE;
          end
          default: begin // EXT_BRK
            do_brk     = 1'b1;
            brk_code   = ext_code;
            state_next = IDLE;
          end
        endcase

        // Typematic repeats re-send the same make; only a change pulses.
        if (do_make && make_code != KEY_NONE) begin
          key_next       = make_code;
          key_valid_next = (make_code != key_reg);
        end
        // Releasing a key other than the one we report leaves key alone.
        if (do_brk && brk_code != KEY_NONE && brk_code == key_reg) begin
          key_next = KEY_NONE;
        end
      end
    end else if (state_reg != IDLE) begin
      if (cnt_reg == TIMEOUT_LAST) begin
        // Orphaned prefix: abandon it but keep the current key.
        state_next = IDLE;
        cnt_next   = '0;
        err_next   = 1'b1;
      end else if (cnt_reg != '1) begin
        cnt_next = cnt_reg + 23'd1;
      end
    end else begin
      cnt_next = '0;
    end

    key_held_next = (key_next != KEY_NONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      key_reg       <= KEY_NONE;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      key_reg       <= key_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
      err_reg       <= err_next;
    end
  end

  assign bus.key       = key_reg;
  assign bus.key_valid = key_valid_reg;
  assign bus.key_held  = key_held_reg;
  assign bus.err       = err_reg;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder -- directed, table-driven check of ps2_key_decoder with
// TIMEOUT_CYCLES=100, plus hand-written timeout and reset sequences.
module tb_ps2_key_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(.TIMEOUT_CYCLES(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic [3:0] key;
    logic       kv;
    logic       held;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] k, input logic kv,
                           input logic h, input logic e);
    check({tag, " key"},       {4'h0, bus.key},         {4'h0, k});
    check({tag, " key_valid"}, {7'h0, bus.key_valid},   {7'h0, kv});
    check({tag, " key_held"},  {7'h0, bus.key_held},    {7'h0, h});
    check({tag, " err"},       {7'h0, bus.err},         {7'h0, e});
  endtask

  // Drive one cycle of input and sample just after the capturing edge.
  task automatic apply(input logic [7:0] d, input logic v);
    @(negedge clk);
    bus.rx_data  = d;
    bus.rx_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all("reset pulse", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add(input logic [7:0] d, input logic v, input logic [3:0] k,
                     input logic kv, input logic h, input logic e);
    vec_t t;
    t.data = d; t.valid = v; t.key = k; t.kv = kv; t.held = h; t.err = e;
    vecs.push_back(t);
  endtask

  initial begin
    int tmo_at;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    // Make/break/typematic/overrun vectors (data, valid -> key, kv, held, err).
    add(8'h1E,1,4'h2,1,1,0); add(8'hF0,1,4'h2,0,1,0); add(8'h1E,1,4'h0,0,0,0);
    add(8'h00,0,4'h0,0,0,0);
    add(8'hE0,1,4'h0,0,0,0); add(8'h75,1,4'hA,1,1,0);
    for (int i = 0; i < 3; i++) begin
      add(8'hE0,1,4'hA,0,1,0); add(8'h75,1,4'hA,0,1,0);
    end
    add(8'hE0,1,4'hA,0,1,0); add(8'hF0,1,4'hA,0,1,0); add(8'h75,1,4'h0,0,0,0);
    add(8'h26,1,4'h3,1,1,0); add(8'h76,1,4'hF,1,1,0);
    add(8'hF0,1,4'hF,0,1,0); add(8'h26,1,4'hF,0,1,0);
    add(8'h25,1,4'h4,1,1,0); add(8'hFF,1,4'h0,0,0,1); add(8'h00,0,4'h0,0,0,0);
    add(8'hF0,1,4'h0,0,0,0); add(8'h25,1,4'h0,0,0,0);
    add(8'h5A,1,4'hE,1,1,0); add(8'hAA,1,4'hE,0,1,0); add(8'hFC,1,4'hE,0,1,0);
    add(8'h1C,1,4'hE,0,1,0); add(8'hFF,0,4'hE,0,1,0);
    add(8'hE0,1,4'hE,0,1,0); add(8'h5A,1,4'hE,0,1,0);
    add(8'hE0,1,4'hE,0,1,0); add(8'hF0,1,4'hE,0,1,0); add(8'h5A,1,4'hE,0,1,0);
    add(8'h00,1,4'h0,0,0,1);
    add(8'hE0,1,4'h0,0,0,0); add(8'h72,1,4'hB,1,1,0);
    add(8'hE0,1,4'hB,0,1,0); add(8'hFF,1,4'h0,0,0,1); add(8'h16,1,4'h1,1,1,0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].data, vecs[i].valid);
      check_all($sformatf("vec[%0d] %02h", i, vecs[i].data),
                vecs[i].key, vecs[i].kv, vecs[i].held, vecs[i].err);
    end

    // Prefix timeout: err expected exactly 100 cycles after the E0 edge.
    apply(8'hE0, 1'b1);
    check_all("tmo E0", 4'h1, 1'b0, 1'b1, 1'b0);
    tmo_at = 0;
    for (int n = 1; n <= 200; n++) begin
      apply(8'h00, 1'b0);
      if (bus.err === 1'b1) begin
        tmo_at = n;
        break;
      end
    end
    check("tmo cycle", 8'(tmo_at), 8'd100);
    check_all("tmo pulse", 4'h1, 1'b0, 1'b1, 1'b1);
    apply(8'h00, 1'b0);
    check_all("tmo after", 4'h1, 1'b0, 1'b1, 1'b0);
    apply(8'h25, 1'b1);
    check_all("tmo then 25", 4'h4, 1'b1, 1'b1, 1'b0);
    apply(8'h16, 1'b1);
    check_all("tmo then 16", 4'h1, 1'b1, 1'b1, 1'b0);

    // Reset after F0 with ENTER held, then 5A is a make again.
    apply(8'h5A, 1'b1);
    check_all("rst 5A", 4'hE, 1'b1, 1'b1, 1'b0);
    apply(8'hF0, 1'b1);
    check_all("rst F0", 4'hE, 1'b0, 1'b1, 1'b0);
    pulse_rst();
    apply(8'h5A, 1'b1);
    check_all("rst then 5A", 4'hE, 1'b1, 1'b1, 1'b0);

    // Reset after E0 discards the prefix: 75 becomes a plain unmapped make.
    apply(8'hE0, 1'b1);
    pulse_rst();
    apply(8'h75, 1'b1);
    check_all("rst E0 then 75", 4'h0, 1'b0, 1'b0, 1'b0);
    apply(8'h16, 1'b1);
    check_all("rst E0 then 16", 4'h1, 1'b1, 1'b1, 1'b0);
    apply(8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
